// File: rtl/ir_protocol_pkg.sv
// ir_protocol_pkg: shared SIRC framing constants, state encoding and command layout
package ir_protocol_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START_MARK,
        ST_START_SPACE,
        ST_BIT_MARK,
        ST_BIT_SPACE,
        ST_GAP
    } ir_state_t;

    localparam int START_UNITS      = 4;
    localparam int ONE_UNITS        = 2;
    localparam int ZERO_UNITS       = 1;
    localparam int SPACE_UNITS      = 1;
    localparam int SIRC_FRAME_UNITS = 75;

    localparam int ANGLE_MSB    = 11;
    localparam int ANGLE_LSB    = 7;
    localparam int DIST_MSB     = 6;
    localparam int DIST_LSB     = 0;
    localparam int COMMAND_BITS = 12;

    function automatic logic [2:0] mark_units(input logic b);
        return b ? 3'(ONE_UNITS) : 3'(ZERO_UNITS);
    endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// ir_carrier_gen: 50% square-wave carrier divider that restarts high on request
module ir_carrier_gen #(
    parameter int HALF_CARRIER = 12
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    output logic carrier
);

    localparam int CW = $clog2(HALF_CARRIER + 1);

    logic [CW-1:0] count;

    // toggle every HALF_CARRIER enabled cycles; restart forces a fresh high half-period
    always_ff @(posedge clock) begin
        if (!reset) begin
            count   <= '0;
            carrier <= 1'b0;
        end else if (restart) begin
            count   <= '0;
            carrier <= 1'b1;
        end else if (enable) begin
            if (count == CW'(HALF_CARRIER - 1)) begin
                count   <= '0;
                carrier <= ~carrier;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ir_command_transmitter.sv
// ir_command_transmitter: serializes a 12-bit rover command into repeated SIRC frames on an IR carrier
module ir_command_transmitter
    import ir_protocol_pkg::*;
#(
    parameter int CLK_HZ      = 27_000_000,
    parameter int CARRIER_HZ  = 40_000,
    parameter int UNIT_US     = 600,
    parameter int FRAME_UNITS = SIRC_FRAME_UNITS,
    parameter int REPEATS     = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    command_ready,
    input  logic [COMMAND_BITS-1:0] command,
    output logic                    ir_out,
    output logic                    busy,
    output logic                    done
);

    localparam int UNIT_CYCLES  = CLK_HZ / 1_000_000 * UNIT_US;
    localparam int HALF_CARRIER = CLK_HZ / (2 * CARRIER_HZ);
    localparam int UW           = $clog2(UNIT_CYCLES + 1);
    localparam int FW           = $clog2(FRAME_UNITS + 1);
    localparam int RW           = $clog2(REPEATS + 1);

    ir_state_t               state, state_next;
    logic [COMMAND_BITS-1:0] cmd_q;
    logic [UW-1:0]           unit_cnt;
    logic [2:0]              seg_cnt, seg_len;
    logic [FW-1:0]           frame_units;
    logic [3:0]              bit_idx;
    logic [RW-1:0]           frame_cnt;
    logic                    unit_tick, seg_end, frame_end, last_bit, last_frame;
    logic                    mark, restart, carrier, done_q;

    assign unit_tick  = unit_cnt == UW'(UNIT_CYCLES - 1);
    assign seg_len    = state == ST_START_MARK ? 3'(START_UNITS) :
                        state == ST_BIT_MARK   ? mark_units(cmd_q[bit_idx]) : 3'(SPACE_UNITS);
    assign seg_end    = unit_tick && seg_cnt == seg_len - 3'd1;
    assign frame_end  = unit_tick && frame_units == FW'(FRAME_UNITS - 1);
    assign last_bit   = bit_idx == 4'(COMMAND_BITS - 1);
    assign last_frame = frame_cnt == RW'(REPEATS - 1);

    // state register
    always_ff @(posedge clock) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    // segment sequencing: marks/spaces advance on whole units, the gap waits for the frame boundary
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:        state_next = command_ready ? ST_START_MARK : ST_IDLE;
            ST_START_MARK:  state_next = seg_end ? ST_START_SPACE : ST_START_MARK;
            ST_START_SPACE: state_next = seg_end ? ST_BIT_MARK : ST_START_SPACE;
            ST_BIT_MARK:    state_next = seg_end ? ST_BIT_SPACE : ST_BIT_MARK;
            ST_BIT_SPACE:   state_next = seg_end ? (last_bit ? ST_GAP : ST_BIT_MARK) : ST_BIT_SPACE;
            ST_GAP:         state_next = frame_end ? (last_frame ? ST_IDLE : ST_START_MARK) : ST_GAP;
            default:        state_next = ST_IDLE;
        endcase
    end

    // outputs: envelope gates the carrier, which restarts on every entry into a mark
    always_comb begin
        mark    = state == ST_START_MARK || state == ST_BIT_MARK;
        restart = !mark && (state_next == ST_START_MARK || state_next == ST_BIT_MARK);
        ir_out  = mark & carrier;
        busy    = state != ST_IDLE;
        done    = done_q;
    end

    // unit, segment, frame, bit and repeat counters plus the latched command
    always_ff @(posedge clock) begin
        if (!reset) begin
            cmd_q       <= '0;
            unit_cnt    <= '0;
            seg_cnt     <= '0;
            frame_units <= '0;
            bit_idx     <= '0;
            frame_cnt   <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= state == ST_GAP && frame_end && last_frame;
            if (state == ST_IDLE) begin
                unit_cnt    <= '0;
                seg_cnt     <= '0;
                frame_units <= '0;
                bit_idx     <= '0;
                frame_cnt   <= '0;
                if (command_ready) cmd_q <= command;
            end else begin
                unit_cnt <= unit_tick ? '0 : unit_cnt + 1'b1;
                if (unit_tick) frame_units <= frame_end ? '0 : frame_units + 1'b1;
                if (unit_tick && state != ST_GAP) seg_cnt <= seg_end ? '0 : seg_cnt + 1'b1;
                if (state == ST_BIT_SPACE && seg_end) bit_idx <= last_bit ? '0 : bit_idx + 1'b1;
                if (state == ST_GAP && frame_end) frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    ir_carrier_gen #(
        .HALF_CARRIER(HALF_CARRIER)
    ) u_carrier (
        .clock  (clock),
        .reset  (reset),
        .enable (mark),
        .restart(restart),
        .carrier(carrier)
    );

endmodule

// File: tb/tb_ir_command_transmitter.sv
// tb_ir_command_transmitter: waveform-level check of SIRC framing, repeats, reset and back-to-back handling
module tb_ir_command_transmitter;
    import ir_protocol_pkg::*;

    localparam int CLK_HZ    = 1_000_000;
    localparam int U         = 20;
    localparam int HC        = 12;
    localparam int FRAME_CYC = 75 * U;
    localparam int SEQ       = 3 * FRAME_CYC;

    logic        clock = 1'b0;
    logic        reset;
    logic        command_ready;
    logic [11:0] command;
    logic        ir_out, busy, done;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [11:0] cmd;
        int          inj_t;
        logic [11:0] inj_cmd;
        logic [11:0] exp_dec;
    } vec_t;

    vec_t tbl[4];

    always #5 clock = ~clock;

    ir_command_transmitter #(
        .CLK_HZ     (CLK_HZ),
        .CARRIER_HZ (40_000),
        .UNIT_US    (U),
        .FRAME_UNITS(75),
        .REPEATS    (3)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .command_ready(command_ready),
        .command      (command),
        .ir_out       (ir_out),
        .busy         (busy),
        .done         (done)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // expected LED drive at cycle t after the first mark, from SIRC timing rules
    function automatic logic model_ir(input logic [11:0] c, input int t);
        int ft, s, len;
        ft = t % FRAME_CYC;
        if (ft < 4 * U) return ((ft / HC) % 2) == 0;
        s = 5 * U;
        for (int i = 0; i < COMMAND_BITS; i++) begin
            len = c[i] ? 2 * U : U;
            if (ft >= s && ft < s + len) return (((ft - s) / HC) % 2) == 0;
            s += len + U;
        end
        return 1'b0;
    endfunction

    task automatic kick(input logic [11:0] c);
        command = c;
        command_ready = 1'b1;
        @(negedge clock);
    endtask

    // called at the negedge of the first mark cycle; ends at the negedge after the done cycle
    task automatic check_seq(input logic [11:0] c, input bit hold, input int inj_t,
                             input logic [11:0] inj_c, input logic [11:0] exp_dec);
        int ir_bad, ctl_bad, first_bad, low_run, highs, bitpos, frames, bad_frames;
        bit in_mark, e_ir;
        logic [11:0] dec;
        ir_bad = 0; ctl_bad = 0; first_bad = -1; low_run = 0; highs = 0;
        bitpos = 12; frames = 0; bad_frames = 0; in_mark = 0; dec = '0;
        for (int t = 0; t <= SEQ; t++) begin
            e_ir = (t < SEQ) && model_ir(c, t);
            if (ir_out !== e_ir) begin
                ir_bad++;
                if (first_bad < 0) first_bad = t;
            end
            if (busy !== (t < SEQ) || done !== (t == SEQ)) ctl_bad++;
            if (ir_out === 1'b1) begin
                if (!in_mark) begin in_mark = 1; highs = 0; end
                highs++;
                low_run = 0;
            end else begin
                low_run++;
                if (in_mark && low_run > HC) begin
                    in_mark = 0;
                    if (highs >= 40) begin
                        bitpos = 0;
                        dec = '0;
                    end else if (bitpos < 12) begin
                        dec[bitpos] = highs >= 20;
                        bitpos++;
                        if (bitpos == 12) begin
                            frames++;
                            if (dec !== exp_dec) bad_frames++;
                        end
                    end
                end
            end
            command_ready = hold || t == inj_t;
            if (t == inj_t) command = inj_c;
            @(negedge clock);
        end
        chk($sformatf("wave cmd=%03h first_bad_cycle=%0d mismatched_cycles", c, first_bad), ir_bad, 0);
        chk($sformatf("busy/done timing cmd=%03h mismatched_cycles", c), ctl_bad, 0);
        chk($sformatf("decoded frames cmd=%03h", c), frames, 3);
        chk($sformatf("decoded value cmd=%03h bad_frames", c), bad_frames, 0);
        if (hold || inj_t == SEQ) begin
            chk("back-to-back busy", int'(busy), 1);
            chk("back-to-back first mark", int'(ir_out), 1);
        end else begin
            chk("after done busy", int'(busy), 0);
            chk("after done pulse width", int'(done), 0);
        end
    endtask

    initial begin
        int cnt_busy, cnt_done, cnt_ir;
        logic [11:0] rc, ric;
        tbl[0] = '{12'h000, -1, 12'h000, 12'h000};
        tbl[1] = '{12'hFFF, -1, 12'h000, 12'hFFF};
        tbl[2] = '{{5'd21, 7'd1}, -1, 12'h000, 12'hA81};
        tbl[3] = '{{5'd21, 7'd1}, 300, 12'h555, 12'hA81};

        reset = 1'b0;
        command_ready = 1'b0;
        command = '0;
        repeat (3) @(negedge clock);
        chk("reset ir_out", int'(ir_out), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        reset = 1'b1;
        @(negedge clock);
        chk("idle busy", int'(busy), 0);

        for (int i = 0; i < 4; i++) begin
            kick(tbl[i].cmd);
            check_seq(tbl[i].cmd, 0, tbl[i].inj_t, tbl[i].inj_cmd, tbl[i].exp_dec);
        end

        kick(12'h35C);
        check_seq(12'h35C, 1, SEQ, 12'h6A3, 12'h35C);
        check_seq(12'h6A3, 0, -1, 12'h000, 12'h6A3);

        kick(12'hFFF);
        repeat (110) @(negedge clock);
        reset = 1'b0;
        command_ready = 1'b0;
        @(negedge clock);
        chk("mid-mark reset ir_out", int'(ir_out), 0);
        chk("mid-mark reset busy", int'(busy), 0);
        chk("mid-mark reset done", int'(done), 0);
        reset = 1'b1;
        cnt_busy = 0; cnt_done = 0; cnt_ir = 0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clock);
            cnt_busy += int'(busy);
            cnt_done += int'(done);
            cnt_ir += int'(ir_out);
        end
        chk("post-reset busy cycles", cnt_busy, 0);
        chk("post-reset done cycles", cnt_done, 0);
        chk("post-reset ir cycles", cnt_ir, 0);
        kick(12'h2B6);
        check_seq(12'h2B6, 0, -1, 12'h000, 12'h2B6);

        for (int r = 0; r < 4; r++) begin
            rc = '0;
            rc[ANGLE_MSB:ANGLE_LSB] = 5'($urandom);
            rc[DIST_MSB:DIST_LSB] = 7'($urandom);
            ric = 12'($urandom);
            kick(rc);
            check_seq(rc, 0, $urandom_range(1, SEQ - 1), ric, rc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
